// File: rtl/alu_search_ctrl_if.sv
// Control, memory and ALU signals of the table-search sequencer.
// The slave view belongs to the sequencer; the master view is its environment.
interface alu_search_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 7
);
  logic              START;
  logic              ABORT;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [IDX_W-1:0]  N_ENTRIES;
  logic [15:0]       KEY_A;
  logic [15:0]       KEY_C;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_RD;
  logic [15:0]       MEM_DATA;
  logic [3:0]        ALU_OP;
  logic [15:0]       ALU_A;
  logic [15:0]       ALU_B;
  logic [15:0]       ALU_C;
  logic [15:0]       ALU_MEMIN;
  logic              ALU_ZERO;
  logic              BUSY;
  logic              DONE;
  logic              FOUND;
  logic [IDX_W-1:0]  FOUND_IDX;

  modport slave (
    input  START, ABORT, BASE_ADDR, N_ENTRIES,
    input  KEY_A, KEY_C, MEM_DATA, ALU_ZERO,
    output MEM_ADDR, MEM_RD, ALU_OP, ALU_A,
    output ALU_B, ALU_C, ALU_MEMIN,
    output BUSY, DONE, FOUND, FOUND_IDX
  );

  modport master (
    output START, ABORT, BASE_ADDR, N_ENTRIES,
    output KEY_A, KEY_C, MEM_DATA, ALU_ZERO,
    input  MEM_ADDR, MEM_RD, ALU_OP, ALU_A,
    input  ALU_B, ALU_C, ALU_MEMIN,
    input  BUSY, DONE, FOUND, FOUND_IDX
  );
endinterface

// File: rtl/alu_search_ctrl.sv
// Table-search sequencer: reads two-word entries and drives the ALU compare.
// Three cycles per entry; first match wins and ends the walk.
module alu_search_ctrl #(
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 7
) (
  input logic              CLK,
  input logic              RESET_N,
  alu_search_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_CMP, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic [15:0]       ka_q, ka_d;
  logic [15:0]       kc_q, kc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       w0_q, w0_d;
  logic              found_q, found_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;

  logic [ADDR_W-1:0] off, a0, a1;
  logic [IDX_W-1:0]  idx_nx;
  logic              last;

  assign off    = ADDR_W'({idx_q, 1'b0});
  assign a0     = base_q + off;
  assign a1     = a0 + ADDR_W'(1);
  assign idx_nx = idx_q + IDX_W'(1);
  assign last   = (idx_nx == n_q);

  assign bus.FOUND     = found_q;
  assign bus.FOUND_IDX = fidx_q;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      n_q     <= '0;
      ka_q    <= '0;
      kc_q    <= '0;
      idx_q   <= '0;
      w0_q    <= '0;
      found_q <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      n_q     <= n_d;
      ka_q    <= ka_d;
      kc_q    <= kc_d;
      idx_q   <= idx_d;
      w0_q    <= w0_d;
      found_q <= found_d;
      fidx_q  <= fidx_d;
    end
  end

  // Next-state logic plus memory/ALU drive for the current state.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    n_d           = n_q;
    ka_d          = ka_q;
    kc_d          = kc_q;
    idx_d         = idx_q;
    w0_d          = w0_q;
    found_d       = found_q;
    fidx_d        = fidx_q;
    bus.MEM_ADDR  = '0;
    bus.MEM_RD    = 1'b0;
    bus.ALU_OP    = 4'd0;
    bus.ALU_A     = '0;
    bus.ALU_B     = '0;
    bus.ALU_C     = '0;
    bus.ALU_MEMIN = '0;
    bus.BUSY      = 1'b0;
    bus.DONE      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          base_d  = bus.BASE_ADDR;
          n_d     = bus.N_ENTRIES;
          ka_d    = bus.KEY_A;
          kc_d    = bus.KEY_C;
          idx_d   = '0;
          found_d = 1'b0;
          fidx_d  = '0;
          state_d = (bus.N_ENTRIES == '0) ? S_FIN : S_RD0;
        end
      end
      S_RD0: begin
        bus.BUSY     = 1'b1;
        bus.MEM_RD   = 1'b1;
        bus.MEM_ADDR = a0;
        if (bus.ABORT) begin
          found_d = 1'b0;
          state_d = S_FIN;
        end else begin
          state_d = S_RD1;
        end
      end
      S_RD1: begin
        bus.BUSY     = 1'b1;
        bus.MEM_RD   = 1'b1;
        bus.MEM_ADDR = a1;
        if (bus.ABORT) begin
          found_d = 1'b0;
          state_d = S_FIN;
        end else begin
          w0_d    = bus.MEM_DATA;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        bus.BUSY      = 1'b1;
        bus.ALU_OP    = 4'd4;
        bus.ALU_A     = ka_q;
        bus.ALU_B     = bus.MEM_DATA;
        bus.ALU_C     = kc_q;
        bus.ALU_MEMIN = w0_q;
        if (bus.ABORT) begin
          found_d = 1'b0;
          state_d = S_FIN;
        end else if (bus.ALU_ZERO) begin
          found_d = 1'b1;
          fidx_d  = idx_q;
          state_d = S_FIN;
        end else if (last) begin
          found_d = 1'b0;
          state_d = S_FIN;
        end else begin
          idx_d   = idx_nx;
          state_d = S_RD0;
        end
      end
      S_FIN: begin
        bus.DONE = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
